// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with pending-write scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;
    localparam int ZERO_ADDR    = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/sb_bit.sv
// One scoreboard pending bit: falling-edge flop, async reset, set beats clear.
module sb_bit (
    input  logic clk,
    input  logic reset,
    input  logic set_i,
    input  logic clr_i,
    output logic pend_o
);

    logic pend_q;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else if (set_i) begin
            pend_q <= 1'b1;
        end else if (clr_i) begin
            pend_q <= 1'b0;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with per-register pending-write scoreboard;
// all state moves on the falling edge so decode sees it later in the same cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_pend_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_pend_b,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall,
    output logic [ADDR_W:0]   pend_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic [CNT_W-1:0]  pend_count_q, pend_count_d;
    logic              issue_zero, wr_zero;
    logic              cnt_inc, cnt_dec;

    assign issue_zero = (ZERO_REG != 0) && (issue_addr == ADDR_W'(ZERO_ADDR));
    assign wr_zero    = (ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_ADDR));

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        if (ZERO_REG != 0 && r == ZERO_ADDR) begin : g_tie
            assign pend[r] = 1'b0;
        end else begin : g_bit
            sb_bit u_bit (
                .clk    (clk),
                .reset  (reset),
                .set_i  (issue_en && (issue_addr == ADDR_W'(r))),
                .clr_i  (wr_en && (wr_addr == ADDR_W'(r))),
                .pend_o (pend[r])
            );
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && !wr_zero) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Count tracks bit transitions rather than re-summing the vector:
    // a 0->1 only on a fresh issue, a 1->0 only on a clear not overridden by a set.
    always_comb begin
        pend_count_d = pend_count_q;
        cnt_inc      = issue_en && !issue_zero && !pend[issue_addr];
        cnt_dec      = wr_en && pend[wr_addr] && !(issue_en && (issue_addr == wr_addr));
        unique case ({cnt_inc, cnt_dec})
            2'b10:   pend_count_d = pend_count_q + CNT_W'(1);
            2'b01:   pend_count_d = pend_count_q - CNT_W'(1);
            default: pend_count_d = pend_count_q;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            pend_count_q <= '0;
        end else begin
            pend_count_q <= pend_count_d;
        end
    end

    assign rd_data_a  = regs_q[rd_addr_a];
    assign rd_data_b  = regs_q[rd_addr_b];
    assign rd_pend_a  = pend[rd_addr_a];
    assign rd_pend_b  = pend[rd_addr_b];
    assign stall      = (rd_en_a && rd_pend_a) || (rd_en_b && rd_pend_b);
    assign pend_count = pend_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table plus hand sequences and a random scoreboard model for regfile_sb.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_en_a, rd_en_b, issue_en, wr_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b, issue_addr, wr_addr;
    logic [DW-1:0] wr_data, rd_data_a, rd_data_b;
    logic          rd_pend_a, rd_pend_b, stall;
    logic [AW:0]   pend_count;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_pend_a  (rd_pend_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_pend_b  (rd_pend_b),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .stall      (stall),
        .pend_count (pend_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iss;
        logic [AW-1:0] iaddr;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          ena;
        logic [AW-1:0] ra;
        logic          enb;
        logic [AW-1:0] rb;
        logic [DW-1:0] exp_da;
        logic [DW-1:0] exp_db;
        logic          exp_pa;
        logic          exp_pb;
        logic          exp_stall;
        logic [AW:0]   exp_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_en = 0; issue_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_en_a = 0; rd_addr_a = '0; rd_en_b = 0; rd_addr_b = '0;
    endtask

    // Reference scoreboard/storage model for the random phase
    logic [DW-1:0] m_regs [NR];
    logic          m_pend [NR];

    function automatic int m_popcount();
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("reset_data_a", 64'(rd_data_a), 64'd0);
        chk("reset_count", 64'(pend_count), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        //        iss ia we wa wdata        ena ra enb rb exp_da        exp_db        pa pb st cnt
        vecs[0]  = '{0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 32'h00001234, 0, 0, 0, 5, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0};
        vecs[2]  = '{1, 7, 0, 0, 32'h0,        1, 7, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1};
        vecs[3]  = '{0, 0, 1, 7, 32'hA5A50007, 1, 7, 0, 0, 32'hA5A50007, 32'h0,        0, 0, 0, 0};
        vecs[4]  = '{1, 3, 0, 0, 32'h0,        0, 3, 1, 3, 32'h0,        32'h0,        1, 1, 1, 1};
        vecs[5]  = '{1, 3, 1, 3, 32'h00000033, 0, 3, 1, 3, 32'h33,       32'h33,       1, 1, 1, 1};
        vecs[6]  = '{1, 9, 0, 0, 32'h0,        1, 9, 0, 0, 32'h0,        32'h0,        1, 0, 1, 2};
        vecs[7]  = '{1, 4, 1, 9, 32'h00000099, 1, 9, 1, 4, 32'h99,       32'h0,        0, 1, 1, 2};
        vecs[8]  = '{1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 2};
        vecs[9]  = '{0, 0, 1, 5, 32'h00000055, 0, 5, 0, 0, 32'h55,       32'h0,        0, 0, 0, 2};
        vecs[10] = '{0, 0, 1, 4, 32'h00000044, 0, 3, 1, 4, 32'h33,       32'h44,       1, 0, 0, 1};
        vecs[11] = '{0, 0, 1, 3, 32'h00000003, 1, 3, 0, 4, 32'h3,        32'h44,       0, 0, 0, 0};
        vecs[12] = '{1, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 32'h0,        32'h0,        0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            issue_en = vecs[i].iss; issue_addr = vecs[i].iaddr;
            wr_en = vecs[i].we; wr_addr = vecs[i].waddr; wr_data = vecs[i].wdata;
            rd_en_a = vecs[i].ena; rd_addr_a = vecs[i].ra;
            rd_en_b = vecs[i].enb; rd_addr_b = vecs[i].rb;
            @(negedge clk); #1;
            chk($sformatf("v%0d_data_a", i), 64'(rd_data_a), 64'(vecs[i].exp_da));
            chk($sformatf("v%0d_data_b", i), 64'(rd_data_b), 64'(vecs[i].exp_db));
            chk($sformatf("v%0d_pend_a", i), 64'(rd_pend_a), 64'(vecs[i].exp_pa));
            chk($sformatf("v%0d_pend_b", i), 64'(rd_pend_b), 64'(vecs[i].exp_pb));
            chk($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
            chk($sformatf("v%0d_count", i), 64'(pend_count), 64'(vecs[i].exp_cnt));
            @(posedge clk); #1;
            idle_inputs();
        end

        // Fill the scoreboard with every non-zero register
        for (int r = 1; r < NR; r++) begin
            issue_en = 1; issue_addr = AW'(r);
            @(negedge clk); #1;
            @(posedge clk); #1;
        end
        idle_inputs();
        rd_en_a = 1; rd_addr_a = 5'd31; rd_en_b = 1; rd_addr_b = 5'd3;
        #1;
        chk("full_count", 64'(pend_count), 64'd31);
        chk("full_stall", 64'(stall), 64'd1);
        chk("full_data_b", 64'(rd_data_b), 64'h3);

        // Asynchronous reset between edges, no clock edge before checking
        #1 reset = 1'b1;
        #1;
        chk("async_count", 64'(pend_count), 64'd0);
        chk("async_stall", 64'(stall), 64'd0);
        chk("async_data_b", 64'(rd_data_b), 64'd0);
        for (int r = 0; r < NR; r++) begin
            rd_addr_a = AW'(r);
            #1;
            chk($sformatf("async_pend_%0d", r), 64'(rd_pend_a), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Random issue/write traffic against the model
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        for (int n = 0; n < 300; n++) begin
            issue_en = 1'($urandom_range(0, 1));
            issue_addr = AW'($urandom_range(0, 7));
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = $urandom;
            rd_en_a = 1'($urandom_range(0, 1));
            rd_addr_a = AW'($urandom_range(0, 7));
            rd_en_b = 1'($urandom_range(0, 1));
            rd_addr_b = AW'($urandom_range(0, 7));
            if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
            if (wr_en) m_pend[wr_addr] = 1'b0;
            if (issue_en) m_pend[issue_addr] = 1'b1;
            m_pend[0] = 1'b0;
            @(negedge clk); #1;
            chk("rand_count", 64'(pend_count), 64'(m_popcount()));
            chk("rand_data_a", 64'(rd_data_a), 64'(m_regs[rd_addr_a]));
            chk("rand_pend_b", 64'(rd_pend_b), 64'(m_pend[rd_addr_b]));
            chk("rand_stall", 64'(stall),
                64'((rd_en_a && m_pend[rd_addr_a]) || (rd_en_b && m_pend[rd_addr_b])));
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-ported register file with an integrated pending-write scoreboard, replacing banks of discrete 1-bit write-enabled flops in the datapath.
- Storage and scoreboard update on the falling clock edge, so a value written in a cycle is readable by the decode stage later in the same cycle.
- Sits between decode (two read ports, issue port) and writeback (one write port).
- Exports per-operand pending flags and a stall request.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1, if 1 then register 0 is hardwired to zero and is never pending.

Ports:
- clk  input  1  clock; all state updates on falling edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rd_en_a  input  1  port A operand is actually used this cycle.
- rd_addr_a  input  ADDR_W  port A read address.
- rd_data_a  output  DATA_W  port A read data (combinational).
- rd_pend_a  output  1  port A register has an outstanding write.
- rd_en_b  input  1  port B operand is actually used.
- rd_addr_b  input  ADDR_W  port B read address.
- rd_data_b  output  DATA_W  port B read data (combinational).
- rd_pend_b  output  1  port B register has an outstanding write.
- issue_en  input  1  an instruction that will write issue_addr is issuing.
- issue_addr  input  ADDR_W  destination register of the issuing instruction.
- wr_en  input  1  writeback valid.
- wr_addr  input  ADDR_W  writeback destination.
- wr_data  input  DATA_W  writeback value.
- stall  output  1  operand hazard: (rd_en_a & rd_pend_a) | (rd_en_b & rd_pend_b).
- pend_count  output  ADDR_W+1  registered count of pending registers.

Behaviour:
- Reset: reset is asynchronous, active-high. While asserted, all registers = 0, all pending bits = 0, pend_count = 0. rd_data_* then read 0, rd_pend_* = 0 and stall = 0. Deassertion takes effect at the next falling edge; reset mid-operation discards any write or issue in flight.
- Write: on the falling edge with wr_en=1, regs[wr_addr] <= wr_data. The write is ignored when ZERO_REG=1 and wr_addr=0.
- Read: rd_data_x = regs[rd_addr_x], combinational from storage with no bypass mux. The falling-edge write makes the new value visible from that edge onward. rd_data_x = 0 for address 0 when ZERO_REG=1.
- Scoreboard, evaluated per register on each falling edge:
  - set = issue_en & issue_addr==r.
  - clr = wr_en & wr_addr==r.
  - set=1 gives pend[r] <= 1. Set wins over a simultaneous clear, because the newer producer is outstanding.
  - set=0 and clr=1 gives pend[r] <= 0.
  - Otherwise pend[r] holds.
  - When ZERO_REG=1, pend[0] is held at 0 regardless of set or clr.
- Data write on a simultaneous set and clear: the write to the same register still updates data.
- Redundant operations:
  - Issue to an already-pending register: bit stays 1, count unchanged.
  - Write to a non-pending register: data updates, count unchanged.
- pend_count:
  - +1 when a bit goes 0->1.
  - -1 when a bit goes 1->0.
  - Net 0 when both happen on the same edge, which requires issue_addr != wr_addr.
- Invariant: pend_count == popcount(pend) at all times. Maximum is NUM_REGS - ZERO_REG, so no overflow is possible.
- Pending outputs: rd_pend_x = pend[rd_addr_x], combinational. A write and clear on a falling edge drops rd_pend_x in the same cycle, so stall releases without an extra cycle.
- Latency: writes and scoreboard changes are visible 0 cycles after the falling edge. There is no pipelining inside the block.
- Read addresses need no rd_en qualification for data. rd_en only gates stall.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W and ADDR_W defaults.
  - NUM_REGS derivation.
  - ZERO_ADDR constant (0).
  - A reg_addr_t typedef.
- One natural sub-module: sb_bit, a single pending flop with async reset, falling-edge clock, and set/clear inputs with set priority.
  - Instantiated NUM_REGS times with a generate loop.
  - The instance for register 0 is tied off when ZERO_REG=1.
- Storage array and pend_count counter stay in the top module.

Test Plan:
1. Reset with arbitrary prior contents -> all rd_data=0, rd_pend=0, pend_count=0, stall=0 immediately on reset assertion, without a clock edge.
2. wr_en=1, wr_addr=5, wr_data=0xDEADBEEF with rd_addr_a=5 -> rd_data_a reads 0xDEADBEEF from the falling edge within the same cycle. Then a write to addr 0 with 0x1234 -> rd_data_a at addr 0 stays 0 (ZERO_REG=1).
3. issue_en to addr 7, then rd_en_a=1 with rd_addr_a=7 -> rd_pend_a=1, stall=1, pend_count=1. Writeback wr_addr=7 -> rd_pend_a=0, stall=0, pend_count=0, data updated.
4. Same falling edge with issue_addr=3 and wr_addr=3 (3 pending) -> pend[3] stays 1, regs[3] updated, pend_count unchanged.
5. Same edge with issue_addr=4 (not pending) and wr_addr=9 (pending) -> pend[4]=1, pend[9]=0, pend_count unchanged. Issue to addr 0 -> pend[0] stays 0, count unchanged.
6. Issue to all 31 non-zero registers -> pend_count=31. Assert reset mid-cycle -> pend_count=0 and all pend=0 asynchronously. Random issue/write sequences -> pend_count matches popcount every cycle.
